fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Producer side of the EX-stage operand-forwarding interface.
- Tracks destination-register information for in-flight instructions through the ID/EX, EX/MEM and MEM/WB stages.
- Generates registered ALU_SrcA_fwd / ALU_SrcB_fwd selects, aligned to the EX cycle. Encoding: 0 = register-file operand, 1 = Fwd_wb, 2 = Fwd_mem.
- Detects load-use hazards, raises a one-cycle stall with bubble insertion, and keeps a saturating stall-event counter.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_W  source A specifier.
- id_rt  input  REG_W  source B specifier.
- id_uses_rs  input  1  operand A is read from the register file.
- id_uses_rt  input  1  operand B comes from the register file (ALU_SrcB_ctrl==0 path).
- id_rd  input  REG_W  destination specifier.
- id_reg_write  input  1  instruction writes rd.
- id_mem_read  input  1  instruction is a load.
- flush  input  1  kill the instruction currently in ID (branch redirect).
- stall  output  1  hold PC and IF/ID; combinational.
- ALU_SrcA_fwd  output  2  registered EX operand-A select.
- ALU_SrcB_fwd  output  2  registered EX operand-B select.
- stall_cnt  output  CNT_W  count of stall cycles.

Behaviour:
- Internal stage records for IDEX, EXMEM and MEMWB. Each record holds {valid, rd, reg_write, mem_read}.
- Reset (rst_n=0, asynchronous): all records cleared to valid=0 and rd=0; ALU_SrcA_fwd=0; ALU_SrcB_fwd=0; stall_cnt=0. stall therefore reads 0.
- Reset has effect immediately, mid-stall included. The first edge after release behaves as a normal cycle.
- "Producer X matches s" means all of: X.valid, X.reg_write, X.rd!=0, X.rd==s.
- Load-use stall (combinational): stall = id_valid & !flush & IDEX.valid & IDEX.mem_read & IDEX.rd!=0 & ((id_uses_rs & IDEX.rd==id_rs) | (id_uses_rt & IDEX.rd==id_rt)).
- Select computation for source s (A uses id_rs/id_uses_rs; B uses id_rt/id_uses_rt):
  - Value 0 if the uses flag is 0 or s==0.
  - Otherwise 2 if IDEX matches s.
  - Otherwise 1 if EXMEM matches s.
  - Otherwise 0.
  - The younger producer has priority, so 2 beats 1.
- Per rising edge, normal case (no stall, no flush): IDEX <= {id_valid, id_rd, id_reg_write, id_mem_read}. Selects registered from the computation above.
- Per rising edge, stall or flush: IDEX <= bubble (all zero) and both selects <= 0.
- Per rising edge, always: EXMEM <= IDEX; MEMWB <= EXMEM.
- Latency: selects reach EX exactly one cycle after the instruction is in ID.
- After a stall, the retried instruction sees the load in EXMEM and takes select 1 (Fwd_wb).
- MEMWB is tracking only. The register file is write-before-read, so an instruction three ahead never needs forwarding.
- flush has priority over stall: stall=0 while flush=1.
- id_valid=0 produces a bubble (selects 0) without asserting stall.
- stall_cnt increments by 1 on every edge where stall=1. It saturates at all-ones and never wraps.
- Stall lasts exactly one cycle per load-use pair. The bubble clears IDEX.mem_read, so stall cannot repeat.

Test Plan:
- Reset: drive rst_n low mid-run, asynchronously between edges. Outputs drop to 0 immediately with no clock edge; IDEX/EXMEM/MEMWB records are verified indirectly by the next scenario's response.
- EX-to-EX: add r3 (reg_write) then sub rs=r3, rt=r4. Next cycle ALU_SrcA_fwd=2, ALU_SrcB_fwd=0, stall never 1.
- MEM-to-EX with priority:
  - add r5; add r5; and rs=r5, rt=r5. Selects are A=2, B=2 (younger wins).
  - Repeat with a nop in the middle. Selects are A=1, B=1.
- Load-use: lw r7, then add rs=r7. stall=1 for one cycle, then a bubble (selects 0), then A=1 on the retried add. stall_cnt increments 0 to 1.
- Filters:
  - Producer with rd=0 gives select 0.
  - Producer with reg_write=0 gives select 0.
  - id_uses_rt=0 with a matching rt gives ALU_SrcB_fwd=0.
  - A load matching only an unused rt gives no stall.
- Flush and saturation:
  - flush asserted during a load-use condition gives stall=0 and selects 0 next cycle.
  - With CNT_W=2, force 5 stalls; stall_cnt stops at 3.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Producer side of the EX-stage operand-forwarding interface. Tracks the
//   destination information of in-flight instructions in ID/EX, EX/MEM and
//   MEM/WB records. It registers the EX operand selects one cycle after the
//   instruction sits in ID, and it detects load-use hazards.
//
//   Select encoding: 0 = register-file operand, 1 = Fwd_wb, 2 = Fwd_mem.
//
//   Flow control: stall is a combinational hold request. While it is high,
//   the upstream stages keep PC and IF/ID, so the same instruction is
//   presented in ID again on the next cycle. This block inserts a bubble
//   into ID/EX in the same cycle. Nothing is exchanged on a valid/ready
//   basis here; id_valid only qualifies the ID contents.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      source A / B specifiers
//   id_uses_rs/rt     operand A / B is read from the register file
//   id_rd             destination specifier
//   id_reg_write      instruction writes rd
//   id_mem_read       instruction is a load
//   flush             kill the instruction in ID (branch redirect)
//   stall             hold PC and IF/ID (combinational)
//   ALU_SrcA_fwd      registered EX operand-A select
//   ALU_SrcB_fwd      registered EX operand-B select
//   stall_cnt         saturating count of stall cycles
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       ALU_SrcA_fwd,
  output logic [1:0]       ALU_SrcB_fwd,
  output logic [CNT_W-1:0] stall_cnt
);

  // Stage records {valid, rd, reg_write, mem_read}
  logic             idex_valid, idex_reg_write, idex_mem_read;
  logic [REG_W-1:0] idex_rd;
  logic             exmem_valid, exmem_reg_write, exmem_mem_read;
  logic [REG_W-1:0] exmem_rd;
  logic             memwb_valid, memwb_reg_write, memwb_mem_read;
  logic [REG_W-1:0] memwb_rd;

  logic       idex_match_a, idex_match_b, exmem_match_a, exmem_match_b;
  logic       bubble;
  logic [1:0] sel_a_next, sel_b_next;

  assign idex_match_a  = idex_valid & idex_reg_write & (idex_rd != '0) & (idex_rd == id_rs);
  assign idex_match_b  = idex_valid & idex_reg_write & (idex_rd != '0) & (idex_rd == id_rt);
  assign exmem_match_a = exmem_valid & exmem_reg_write & (exmem_rd != '0) & (exmem_rd == id_rs);
  assign exmem_match_b = exmem_valid & exmem_reg_write & (exmem_rd != '0) & (exmem_rd == id_rt);

  // A load in ID/EX cannot supply its data to the next instruction's EX,
  // so one bubble is needed. flush wins: a killed instruction needs no hold.
  assign stall = id_valid & ~flush & idex_valid & idex_mem_read & (idex_rd != '0) &
                 ((id_uses_rs & (idex_rd == id_rs)) | (id_uses_rt & (idex_rd == id_rt)));

  assign bubble = stall | flush;

  // The younger producer (ID/EX) has priority over EX/MEM.
  always_comb begin
    sel_a_next = 2'd0;
    if (id_valid && id_uses_rs && (id_rs != '0)) begin
      if (idex_match_a)       sel_a_next = 2'd2;
      else if (exmem_match_a) sel_a_next = 2'd1;
    end
    sel_b_next = 2'd0;
    if (id_valid && id_uses_rt && (id_rt != '0)) begin
      if (idex_match_b)       sel_b_next = 2'd2;
      else if (exmem_match_b) sel_b_next = 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid      <= 1'b0;
      idex_rd         <= '0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      exmem_valid     <= 1'b0;
      exmem_rd        <= '0;
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      memwb_valid     <= 1'b0;
      memwb_rd        <= '0;
      memwb_reg_write <= 1'b0;
      memwb_mem_read  <= 1'b0;
      ALU_SrcA_fwd    <= 2'd0;
      ALU_SrcB_fwd    <= 2'd0;
      stall_cnt       <= '0;
    end else begin
      if (bubble) begin
        idex_valid     <= 1'b0;
        idex_rd        <= '0;
        idex_reg_write <= 1'b0;
        idex_mem_read  <= 1'b0;
        ALU_SrcA_fwd   <= 2'd0;
        ALU_SrcB_fwd   <= 2'd0;
      end else begin
        idex_valid     <= id_valid;
        idex_rd        <= id_rd;
        idex_reg_write <= id_reg_write;
        idex_mem_read  <= id_mem_read;
        ALU_SrcA_fwd   <= sel_a_next;
        ALU_SrcB_fwd   <= sel_b_next;
      end
      exmem_valid     <= idex_valid;
      exmem_rd        <= idex_rd;
      exmem_reg_write <= idex_reg_write;
      exmem_mem_read  <= idex_mem_read;
      memwb_valid     <= exmem_valid;
      memwb_rd        <= exmem_rd;
      memwb_reg_write <= exmem_reg_write;
      memwb_mem_read  <= exmem_mem_read;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // MEM/WB is kept for tracking only. The register file writes before it
  // reads, so nothing three ahead ever needs forwarding.
  logic unused_tracking;
  assign unused_tracking = ^{memwb_valid, memwb_rd, memwb_reg_write, memwb_mem_read,
                             exmem_mem_read};

endmodule
